// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush arbitration, per-stage enables/bubbles and valid tracking for an N-stage pipe.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic [NUM_STAGES-1:0] flush_req,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] kill,
    output logic [NUM_STAGES-1:0] stage_valid,
    input  logic                  perf_clr,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      retire_cnt
);
    logic s_any, f_any, flush_win, stall_win;
    int   s_idx, f_idx;
    logic unused_flush0;

    assign unused_flush0 = flush_req[0];

    always_comb begin
        s_any = 1'b0;
        s_idx = 0;
        f_any = 1'b0;
        f_idx = 0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (stall_req[k]) begin
                s_any = 1'b1;
                s_idx = k;
            end
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (flush_req[k]) begin
                f_any = 1'b1;
                f_idx = k;
            end
        end
        // a flush at or beyond the oldest stall squashes the stalled work anyway
        flush_win = f_any && (!s_any || f_idx >= s_idx);
        stall_win = s_any && !flush_win;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_en[k] = start && !(stall_win && k <= s_idx);
            kill[k]     = start && k != 0 && (flush_win ? k <= f_idx : stall_win && k == s_idx + 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stage_valid <= '0;
        else if (start) begin
            stage_valid[0] <= 1'b1;
            for (int k = 1; k < NUM_STAGES; k++)
                if (stage_en[k])
                    stage_valid[k] <= kill[k] ? 1'b0 : stage_valid[k-1];
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (perf_clr) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (start) begin
            cycle_cnt  <= cycle_cnt + 1'b1;
            stall_cnt  <= stall_cnt + CNT_W'(stall_win);
            flush_cnt  <= flush_cnt + CNT_W'(flush_win);
            retire_cnt <= retire_cnt + CNT_W'(stage_valid[NUM_STAGES-1] && stage_en[NUM_STAGES-1]);
        end
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign cycle_cnt  = '0;
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: randomized and directed checks of pipeline_sequencer against a behavioural model.
module tb_pipeline_sequencer;
    localparam int N = 5;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, perf_clr = 1'b0;
    logic [N-1:0] stall_req = '0, flush_req = '0, stage_en, kill, stage_valid;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt, retire_cnt;
    logic [N-1:0] mv, me, mk;
    logic [31:0] mc_cyc, mc_stl, mc_fl, mc_ret;
    logic m_stall, m_flush;
    int n_cmp = 0, n_err = 0;

    pipeline_sequencer #(.NUM_STAGES(N), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .stall_req(stall_req), .flush_req(flush_req),
        .stage_en(stage_en), .kill(kill), .stage_valid(stage_valid), .perf_clr(perf_clr),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // expected controls from the arbitration rules, using masks built by arithmetic
    task automatic model_ctrl();
        int s = -1, f = -1;
        for (int k = 0; k < N; k++) if (stall_req[k]) s = k;
        for (int k = 1; k < N; k++) if (flush_req[k]) f = k;
        m_flush = start && f >= 0 && (s < 0 || f >= s);
        m_stall = start && s >= 0 && !m_flush;
        if (!start) begin
            me = '0; mk = '0;
        end else if (m_flush) begin
            me = '1; mk = N'(((1 << (f + 1)) - 1) & ~1);
        end else if (m_stall) begin
            me = N'(~((1 << (s + 1)) - 1));
            mk = (s + 1 < N) ? N'(1 << (s + 1)) : '0;
        end else begin
            me = '1; mk = '0;
        end
    endtask

    task automatic model_reset();
        mv = '0; mc_cyc = 0; mc_stl = 0; mc_fl = 0; mc_ret = 0;
    endtask

    task automatic check_counters();
`ifdef PIPE_PERF_CNT_EN
        check("cycle_cnt", cycle_cnt, mc_cyc);
        check("stall_cnt", stall_cnt, mc_stl);
        check("flush_cnt", flush_cnt, mc_fl);
        check("retire_cnt", retire_cnt, mc_ret);
`else
        check("cnt_tied", {cycle_cnt | stall_cnt | flush_cnt | retire_cnt}, 0);
`endif
    endtask

    task automatic step(input logic st, input logic [N-1:0] sr, input logic [N-1:0] fr, input logic clr);
        logic [N-1:0] old;
        start = st; stall_req = sr; flush_req = fr; perf_clr = clr;
        #1;
        model_ctrl();
        check("stage_en", stage_en, me);
        check("kill", kill, mk);
        check("valid", stage_valid, mv);
        check_counters();
        old = mv;
        if (clr) begin
            mc_cyc = 0; mc_stl = 0; mc_fl = 0; mc_ret = 0;
        end else if (st) begin
            mc_cyc++;
            mc_stl += 32'(m_stall);
            mc_fl  += 32'(m_flush);
            mc_ret += 32'(old[N-1] && me[N-1]);
        end
        if (st) begin
            mv[0] = 1'b1;
            for (int k = 1; k < N; k++) if (me[k]) mv[k] = mk[k] ? 1'b0 : old[k-1];
        end
        @(posedge clk);
        #1;
        check("valid_post", stage_valid, mv);
    endtask

    initial begin
        model_reset();
        stall_req = 5'b01010; flush_req = 5'b00100;
        #2;
        check("rst_en", stage_en, 0);
        check("rst_kill", kill, 0);
        check("rst_valid", stage_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 5'b00000, 5'b00000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 5'b00000, 5'b00000, 1'b0);
        check("fill", stage_valid, 5'b11111);
        step(1'b1, 5'b00010, 5'b00000, 1'b0);
        check("stall1_en", me, 5'b11100);
        check("stall1_valid2", stage_valid[2], 1'b0);
        step(1'b1, 5'b00100, 5'b01000, 1'b0);
        check("flushwin_kill", mk, 5'b01110);
        check("flushwin_valid", stage_valid, 5'b10001);
        step(1'b1, 5'b01000, 5'b00010, 1'b0);
        check("stallwin_kill", mk, 5'b10000);
        step(1'b1, 5'b10000, 5'b00000, 1'b0);
        check("hold_en", me, 5'b00000);
        #2 rst = 1'b1;
        #1 check("async_rst_valid", stage_valid, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 5'b00000, 5'b00000, 1'b0);
        step(1'b1, 5'b00000, 5'b00000, 1'b1);
        for (int i = 0; i < 10; i++)
            step(1'b1, (i == 2 || i == 6) ? 5'b00100 : 5'b00000, (i == 4) ? 5'b01000 : 5'b00000, 1'b0);
`ifdef PIPE_PERF_CNT_EN
        check("perf_cycle10", cycle_cnt, 10);
        check("perf_stall2", stall_cnt, 2);
        check("perf_flush1", flush_cnt, 1);
`endif
        step(1'b1, 5'b00000, 5'b00000, 1'b1);
        check_counters();
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) != 0,
                 ($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
                 ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
                 $urandom_range(0, 40) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
